// File: rtl/adaptor_pkg.sv
// Shared types and sizing for the L2 line <-> 64-bit burst memory adaptor.
package adaptor_pkg;

    localparam int unsigned LINE_W   = 256;
    localparam int unsigned BURST_W  = 64;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned CNT_W    = 32;
    localparam int unsigned BEATS    = LINE_W / BURST_W;
    localparam int unsigned IDX_W    = $clog2(BEATS);
    localparam int unsigned BEAT_SH  = $clog2(BURST_W);
    localparam int unsigned OFFSET_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Serialises 256-bit L2 line writes into four 64-bit memory beats and
// assembles four read beats into a line; keeps saturating transaction counts.
module cacheline_adaptor
    import adaptor_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [LINE_W-1:0]   line_i,
    output logic [LINE_W-1:0]   line_o,
    input  logic [ADDR_W-1:0]   address_i,
    input  logic                read_i,
    input  logic                write_i,
    output logic                resp_o,
    input  logic [BURST_W-1:0]  burst_i,
    output logic [BURST_W-1:0]  burst_o,
    output logic [ADDR_W-1:0]   address_o,
    output logic                read_o,
    output logic                write_o,
    input  logic                resp_i,
    output logic [CNT_W-1:0]    rd_txn_count,
    output logic [CNT_W-1:0]    wr_txn_count
);

    adaptor_state_t     r_state;
    adaptor_state_t     w_state_nxt;

    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [IDX_W-1:0]   w_idx_inc;
    logic               w_last_beat;

    logic [LINE_W-1:0]  r_buf;
    logic [LINE_W-1:0]  w_buf_nxt;
    logic [LINE_W-1:0]  r_line;
    logic [LINE_W-1:0]  w_line_nxt;
    logic [BURST_W-1:0] r_burst;
    logic [BURST_W-1:0] w_burst_nxt;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic               r_read;
    logic               w_read_nxt;
    logic               r_write;
    logic               w_write_nxt;
    logic               r_resp;
    logic               w_resp_nxt;
    logic [CNT_W-1:0]   r_rd_cnt;
    logic [CNT_W-1:0]   w_rd_cnt_nxt;
    logic [CNT_W-1:0]   r_wr_cnt;
    logic [CNT_W-1:0]   w_wr_cnt_nxt;

    assign w_idx_inc   = r_idx + IDX_W'(1);
    assign w_last_beat = resp_i && (r_idx == IDX_W'(BEATS - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; write wins over read when both are requested
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (write_i) begin
                    w_state_nxt = WRITE;
                end else if (read_i) begin
                    w_state_nxt = READ;
                end
            end
            READ:    if (w_last_beat) w_state_nxt = DONE;
            WRITE:   if (w_last_beat) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output and datapath next values, registered below
    always_comb begin
        w_idx_nxt    = r_idx;
        w_buf_nxt    = r_buf;
        w_line_nxt   = r_line;
        w_burst_nxt  = r_burst;
        w_addr_nxt   = r_addr;
        w_rd_cnt_nxt = r_rd_cnt;
        w_wr_cnt_nxt = r_wr_cnt;
        w_read_nxt   = (w_state_nxt == READ);
        w_write_nxt  = (w_state_nxt == WRITE);
        w_resp_nxt   = (w_state_nxt == DONE);
        case (r_state)
            IDLE: begin
                if (write_i || read_i) begin
                    w_idx_nxt  = '0;
                    w_addr_nxt = {address_i[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
                    if (write_i) begin
                        w_buf_nxt   = line_i;
                        w_burst_nxt = line_i[BURST_W-1:0];
                    end
                end
            end
            READ: begin
                if (resp_i) begin
                    w_idx_nxt = w_idx_inc;
                    w_buf_nxt[{r_idx, BEAT_SH'(0)} +: BURST_W] = burst_i;
                    if (w_last_beat) begin
                        w_line_nxt = {burst_i, r_buf[LINE_W-BURST_W-1:0]};
                        if (r_rd_cnt != '1) begin
                            w_rd_cnt_nxt = r_rd_cnt + CNT_W'(1);
                        end
                    end
                end
            end
            WRITE: begin
                if (resp_i) begin
                    w_idx_nxt = w_idx_inc;
                    if (w_last_beat) begin
                        if (r_wr_cnt != '1) begin
                            w_wr_cnt_nxt = r_wr_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_burst_nxt = r_buf[{w_idx_inc, BEAT_SH'(0)} +: BURST_W];
                    end
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and beat storage; reset aborts any transaction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx    <= '0;
            r_buf    <= '0;
            r_line   <= '0;
            r_burst  <= '0;
            r_addr   <= '0;
            r_read   <= 1'b0;
            r_write  <= 1'b0;
            r_resp   <= 1'b0;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            r_idx    <= w_idx_nxt;
            r_buf    <= w_buf_nxt;
            r_line   <= w_line_nxt;
            r_burst  <= w_burst_nxt;
            r_addr   <= w_addr_nxt;
            r_read   <= w_read_nxt;
            r_write  <= w_write_nxt;
            r_resp   <= w_resp_nxt;
            r_rd_cnt <= w_rd_cnt_nxt;
            r_wr_cnt <= w_wr_cnt_nxt;
        end
    end

    assign line_o       = r_line;
    assign burst_o      = r_burst;
    assign address_o    = r_addr;
    assign read_o       = r_read;
    assign write_o      = r_write;
    assign resp_o       = r_resp;
    assign rd_txn_count = r_rd_cnt;
    assign wr_txn_count = r_wr_cnt;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Bench for cacheline_adaptor: an L2-side requester and a memory model with
// random beat gaps, checked against a line-level reference model.
module tb_cacheline_adaptor;
    import adaptor_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [LINE_W-1:0]  line_i = '0;
    logic [LINE_W-1:0]  line_o;
    logic [ADDR_W-1:0]  address_i = '0;
    logic               read_i = 1'b0;
    logic               write_i = 1'b0;
    logic               resp_o;
    logic [BURST_W-1:0] burst_i = '0;
    logic [BURST_W-1:0] burst_o;
    logic [ADDR_W-1:0]  address_o;
    logic               read_o;
    logic               write_o;
    logic               resp_i = 1'b0;
    logic [CNT_W-1:0]   rd_txn_count;
    logic [CNT_W-1:0]   wr_txn_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0]  m_rd_cnt = '0;
    logic [31:0]  m_wr_cnt = '0;
    logic [255:0] m_line   = '0;

    cacheline_adaptor dut (
        .clk          (clk),
        .rst          (rst),
        .line_i       (line_i),
        .line_o       (line_o),
        .address_i    (address_i),
        .read_i       (read_i),
        .write_i      (write_i),
        .resp_o       (resp_o),
        .burst_i      (burst_i),
        .burst_o      (burst_o),
        .address_o    (address_o),
        .read_o       (read_o),
        .write_o      (write_o),
        .resp_i       (resp_i),
        .rd_txn_count (rd_txn_count),
        .wr_txn_count (wr_txn_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // L2 requester plus memory: gaps[i] idle cycles precede beat i
    task automatic run_txn(input bit wr, input bit rd, input logic [31:0] addr,
                           input logic [255:0] wline, input logic [255:0] rline,
                           input int gaps [4],
                           output logic [255:0] obs_bursts, output int lat,
                           output bit ctrl_ok);
        int beats;
        int gap;
        bit beat_prev;
        logic [63:0] prev_burst;
        logic [31:0] exp_addr;
        exp_addr   = addr & 32'hFFFF_FFE0;
        ctrl_ok    = 1'b1;
        lat        = -1;
        beats      = 0;
        gap        = gaps[0];
        beat_prev  = 1'b0;
        obs_bursts = '0;
        @(negedge clk);
        write_i = wr; read_i = rd; address_i = addr; line_i = wline;
        prev_burst = burst_o;
        for (int t = 1; t <= 200; t++) begin
            @(negedge clk);
            resp_i  = 1'b0;
            burst_i = {$urandom, $urandom};
            if (resp_o === 1'b1) begin
                lat = t;
                if (read_o !== 1'b0 || write_o !== 1'b0) ctrl_ok = 1'b0;
                write_i = 1'b0; read_i = 1'b0;
                break;
            end
            if (wr ? (write_o !== 1'b1 || read_o !== 1'b0)
                   : (read_o !== 1'b1 || write_o !== 1'b0)) ctrl_ok = 1'b0;
            if (address_o !== exp_addr) ctrl_ok = 1'b0;
            if (wr && t > 1 && !beat_prev && burst_o !== prev_burst) ctrl_ok = 1'b0;
            prev_burst = burst_o;
            beat_prev  = 1'b0;
            if (beats < 4) begin
                if (gap > 0) begin
                    gap--;
                end else begin
                    resp_i  = 1'b1;
                    burst_i = rline[beats*64 +: 64];
                    obs_bursts[beats*64 +: 64] = burst_o;
                    beats++;
                    beat_prev = 1'b1;
                    if (beats < 4) gap = gaps[beats];
                end
            end
        end
        if (lat < 0) begin
            write_i = 1'b0; read_i = 1'b0; resp_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0) begin
            n_err++; $display("FAIL reset_ctrl got r=%b w=%b resp=%b want 0 0 0", read_o, write_o, resp_o); end
        n_cmp++; if (line_o !== '0 || burst_o !== '0 || address_o !== '0) begin
            n_err++; $display("FAIL reset_data got line=%h burst=%h addr=%h want 0", line_o, burst_o, address_o); end
        n_cmp++; if (rd_txn_count !== 32'd0 || wr_txn_count !== 32'd0) begin
            n_err++; $display("FAIL reset_cnt got rd=%0d wr=%0d want 0 0", rd_txn_count, wr_txn_count); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read_zero_wait();
        logic [255:0] rl;
        logic [255:0] ob;
        int lat;
        bit ok;
        int g [4];
        g  = '{0, 0, 0, 0};
        rl = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
        run_txn(1'b0, 1'b1, 32'h0000_1234, '0, rl, g, ob, lat, ok);
        m_rd_cnt = sat_inc(m_rd_cnt);
        m_line   = rl;
        n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL read0_latency got %0d want 5", lat); end
        n_cmp++; if (!ok) begin n_err++; $display("FAIL read0_ctrl got bad read_o/address_o want steady"); end
        n_cmp++; if (address_o !== 32'h0000_1220) begin
            n_err++; $display("FAIL read0_addr got %h want 00001220", address_o); end
        n_cmp++; if (line_o !== m_line) begin n_err++; $display("FAIL read0_line got %h want %h", line_o, m_line); end
        n_cmp++; if (rd_txn_count !== m_rd_cnt) begin
            n_err++; $display("FAIL read0_cnt got %0d want %0d", rd_txn_count, m_rd_cnt); end
        @(negedge clk);
        n_cmp++; if (resp_o !== 1'b0) begin n_err++; $display("FAIL read0_resp_width got %b want 0", resp_o); end
    endtask

    task automatic test_write_gap();
        logic [255:0] wl;
        logic [255:0] ob;
        int lat;
        bit ok;
        int g [4];
        g  = '{0, 0, 2, 0};
        wl = rand_line();
        run_txn(1'b1, 1'b0, $urandom, wl, rand_line(), g, ob, lat, ok);
        m_wr_cnt = sat_inc(m_wr_cnt);
        n_cmp++; if (ob !== wl) begin n_err++; $display("FAIL wgap_bursts got %h want %h", ob, wl); end
        n_cmp++; if (!ok) begin n_err++; $display("FAIL wgap_ctrl got write_o drop or burst_o change off-beat want steady"); end
        n_cmp++; if (lat !== 7) begin n_err++; $display("FAIL wgap_latency got %0d want 7", lat); end
        n_cmp++; if (wr_txn_count !== m_wr_cnt || rd_txn_count !== m_rd_cnt) begin
            n_err++; $display("FAIL wgap_cnt got rd=%0d wr=%0d want %0d %0d", rd_txn_count, wr_txn_count, m_rd_cnt, m_wr_cnt); end
        n_cmp++; if (line_o !== m_line) begin n_err++; $display("FAIL wgap_line_hold got %h want %h", line_o, m_line); end
    endtask

    task automatic test_simultaneous();
        logic [255:0] wl;
        logic [255:0] ob;
        int lat;
        bit ok;
        int g [4];
        g  = '{1, 0, 0, 1};
        wl = rand_line();
        run_txn(1'b1, 1'b1, $urandom, wl, rand_line(), g, ob, lat, ok);
        m_wr_cnt = sat_inc(m_wr_cnt);
        n_cmp++; if (!ok || ob !== wl) begin n_err++; $display("FAIL both_is_write got ok=%b bursts=%h want 1 %h", ok, ob, wl); end
        n_cmp++; if (rd_txn_count !== m_rd_cnt || wr_txn_count !== m_wr_cnt) begin
            n_err++; $display("FAIL both_cnt got rd=%0d wr=%0d want %0d %0d", rd_txn_count, wr_txn_count, m_rd_cnt, m_wr_cnt); end
        n_cmp++; if (line_o !== m_line) begin n_err++; $display("FAIL both_line got %h want %h", line_o, m_line); end
    endtask

    task automatic test_spurious_idle();
        logic [255:0] rl;
        logic [255:0] ob;
        int lat;
        bit ok;
        int g [4];
        bit pat [6];
        pat = '{1, 1, 0, 1, 1, 1};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            resp_i  = pat[i];
            burst_i = {$urandom, $urandom};
            n_cmp++; if (resp_o !== 1'b0 || read_o !== 1'b0 || write_o !== 1'b0) begin
                n_err++; $display("FAIL idle_spurious[%0d] got resp=%b r=%b w=%b want 0 0 0", i, resp_o, read_o, write_o); end
        end
        @(negedge clk);
        resp_i = 1'b0;
        n_cmp++; if (resp_o !== 1'b0 || rd_txn_count !== m_rd_cnt || wr_txn_count !== m_wr_cnt) begin
            n_err++; $display("FAIL idle_spurious_end got resp=%b rd=%0d wr=%0d want 0 %0d %0d", resp_o, rd_txn_count, wr_txn_count, m_rd_cnt, m_wr_cnt); end
        g  = '{0, 0, 0, 0};
        rl = rand_line();
        run_txn(1'b0, 1'b1, $urandom, '0, rl, g, ob, lat, ok);
        m_rd_cnt = sat_inc(m_rd_cnt);
        m_line   = rl;
        n_cmp++; if (lat !== 5 || line_o !== m_line) begin
            n_err++; $display("FAIL idle_after_read got lat=%0d line=%h want 5 %h", lat, line_o, m_line); end
    endtask

    task automatic test_reset_mid_read();
        logic [255:0] rl;
        logic [255:0] ob;
        int lat;
        bit ok;
        int g [4];
        @(negedge clk);
        read_i = 1'b1; address_i = $urandom;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            resp_i = 1'b1; burst_i = {$urandom, $urandom};
        end
        @(negedge clk);
        resp_i = 1'b0;
        n_cmp++; if (read_o !== 1'b1) begin n_err++; $display("FAIL rstmid_pre got read_o=%b want 1", read_o); end
        #2 rst = 1'b0;
        #1;
        read_i = 1'b0;
        m_rd_cnt = '0; m_wr_cnt = '0; m_line = '0;
        n_cmp++; if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0) begin
            n_err++; $display("FAIL rstmid_ctrl got r=%b w=%b resp=%b want 0 0 0", read_o, write_o, resp_o); end
        n_cmp++; if (line_o !== '0 || burst_o !== '0 || address_o !== '0 || rd_txn_count !== 32'd0 || wr_txn_count !== 32'd0) begin
            n_err++; $display("FAIL rstmid_data got line=%h burst=%h addr=%h rd=%0d wr=%0d want all 0", line_o, burst_o, address_o, rd_txn_count, wr_txn_count); end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_cmp++; if (resp_o !== 1'b0 || read_o !== 1'b0) begin
                n_err++; $display("FAIL rstmid_quiet got resp=%b read_o=%b want 0 0", resp_o, read_o); end
        end
        g  = '{0, 0, 0, 0};
        rl = rand_line();
        run_txn(1'b0, 1'b1, $urandom, '0, rl, g, ob, lat, ok);
        m_rd_cnt = sat_inc(m_rd_cnt);
        m_line   = rl;
        n_cmp++; if (lat !== 5 || !ok || line_o !== m_line || rd_txn_count !== m_rd_cnt) begin
            n_err++; $display("FAIL rstmid_fresh got lat=%0d ok=%b line=%h rd=%0d want 5 1 %h %0d", lat, ok, line_o, rd_txn_count, m_line, m_rd_cnt); end
    endtask

    task automatic test_random();
        logic [255:0] wl;
        logic [255:0] rl;
        logic [255:0] ob;
        logic [31:0] addr;
        int lat;
        int exp_lat;
        bit ok;
        bit wr;
        bit rd;
        int g [4];
        for (int n = 0; n < 16; n++) begin
            wr = 1'($urandom_range(1, 0));
            rd = wr ? 1'($urandom_range(1, 0)) : 1'b1;
            exp_lat = 5;
            for (int i = 0; i < 4; i++) begin
                g[i] = int'($urandom_range(3, 0));
                exp_lat += g[i];
            end
            addr = $urandom;
            wl = rand_line();
            rl = rand_line();
            run_txn(wr, rd, addr, wl, rl, g, ob, lat, ok);
            if (wr) m_wr_cnt = sat_inc(m_wr_cnt);
            else begin m_rd_cnt = sat_inc(m_rd_cnt); m_line = rl; end
            n_cmp++; if (lat !== exp_lat || !ok) begin
                n_err++; $display("FAIL rand[%0d]_timing got lat=%0d ok=%b want %0d 1", n, lat, ok, exp_lat); end
            n_cmp++; if (line_o !== m_line || (wr && ob !== wl)) begin
                n_err++; $display("FAIL rand[%0d]_data got line=%h bursts=%h want %h", n, line_o, ob, wr ? wl : m_line); end
            n_cmp++; if (rd_txn_count !== m_rd_cnt || wr_txn_count !== m_wr_cnt) begin
                n_err++; $display("FAIL rand[%0d]_cnt got rd=%0d wr=%0d want %0d %0d", n, rd_txn_count, wr_txn_count, m_rd_cnt, m_wr_cnt); end
        end
    endtask

    task automatic test_saturation();
        logic [255:0] rl;
        logic [255:0] ob;
        int lat;
        bit ok;
        int g [4];
        @(negedge clk);
        force dut.r_rd_cnt = 32'hFFFF_FFFF;
        #1 release dut.r_rd_cnt;
        m_rd_cnt = 32'hFFFF_FFFF;
        n_cmp++; if (rd_txn_count !== m_rd_cnt) begin
            n_err++; $display("FAIL sat_preset got %h want %h", rd_txn_count, m_rd_cnt); end
        g  = '{0, 1, 0, 0};
        rl = rand_line();
        run_txn(1'b0, 1'b1, $urandom, '0, rl, g, ob, lat, ok);
        m_rd_cnt = sat_inc(m_rd_cnt);
        m_line   = rl;
        n_cmp++; if (rd_txn_count !== m_rd_cnt || wr_txn_count !== m_wr_cnt) begin
            n_err++; $display("FAIL sat_hold got rd=%h wr=%0d want %h %0d", rd_txn_count, wr_txn_count, m_rd_cnt, m_wr_cnt); end
        n_cmp++; if (line_o !== m_line || lat !== 6) begin
            n_err++; $display("FAIL sat_read got lat=%0d line=%h want 6 %h", lat, line_o, m_line); end
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_gap();
        test_simultaneous();
        test_spurious_idle();
        test_random();
        test_reset_mid_read();
        test_saturation();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
